datapath_seq_ctrl: RTL and testbench
====================================

DATAPATH_SEQ_CTRL -- requirements
Module: datapath_seq_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 4: width of the iteration count and counter.
REQ-002 SHALL provide clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide start  input  1  request to run one program; sampled only in IDLE.
REQ-005 SHALL provide abort  input  1  synchronous cancel of a running program.
REQ-006 SHALL provide n_iter  input  CNT_W  number of loop iterations; latched when start is accepted.
REQ-007 SHALL provide LX, LS, LH, H  output  1 each  datapath register-load and H-select strobes.
REQ-008 SHALL provide M0, M1, M2  output  2 each  datapath mux selects.
REQ-009 SHALL provide busy  output  1  high in every state except IDLE.
REQ-010 SHALL provide done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide iter_cnt  output  CNT_W  completed-iteration count of the current or last program.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, LOADX, STEP1, STEP2, STEP3, STEP4, DONE; all datapath outputs decode from state only.
REQ-013 SHALL drive, in IDLE and DONE: M0=0 M1=0 M2=0, LX=LS=LH=H=0.
REQ-014 SHALL drive in LOADX: M0=0 LX=1 M1=1 M2=0 LS=0 LH=1 H=1.
REQ-015 SHALL drive in STEP1: M0=1 LX=0 M1=0 M2=3 LS=1 LH=0 H=1.
REQ-016 SHALL drive in STEP2: M0=2 LX=0 M1=0 M2=0 LS=0 LH=1 H=1.
REQ-017 SHALL drive in STEP3: M0=0 LX=0 M1=2 M2=3 LS=1 LH=0 H=0.
REQ-018 SHALL drive in STEP4: M0=3 LX=0 M1=0 M2=2 LS=1 LH=0 H=0.
REQ-019 SHALL transition IDLE->LOADX when start=1 and abort=0; otherwise stay IDLE.
REQ-020 SHALL latch n_iter on the IDLE->LOADX edge; latched value 0 is treated as 1.
REQ-021 SHALL transition LOADX->STEP1->STEP2->STEP3->STEP4 unconditionally, one state per cycle.
REQ-022 SHALL, on leaving STEP4, increment iter_cnt and go to STEP1 if the incremented count < latched n_iter, else to DONE.
REQ-023 SHALL clear iter_cnt to 0 on the IDLE->LOADX edge; iter_cnt holds its final value in DONE and IDLE until the next accepted start.
REQ-024 SHALL assert done only in DONE (exactly one cycle), then go DONE->IDLE unconditionally.
REQ-025 SHALL place DONE exactly 4*N+1 rising edges after the edge that accepts start, N = effective iteration count.
REQ-026 SHALL ignore start while busy=1; no restart and no change to latched n_iter.
REQ-027 SHALL, when abort=1 in any non-IDLE state, go to IDLE on the next edge without visiting DONE and without a done pulse; iter_cnt holds.
REQ-028 SHALL give abort priority over start in IDLE: start is not accepted while abort=1.
REQ-029 SHALL never leave an illegal state encoding undecoded; any unused encoding returns to IDLE on the next edge with all outputs 0.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, force state IDLE, iter_cnt=0, latched n_iter=1, irrespective of start or abort.
REQ-031 SHALL, after reset, present busy=0, done=0, LX=LS=LH=H=0, M0=M1=M2=0.
REQ-032 SHALL let reset mid-program terminate it immediately with no done pulse.

Verification
REQ-033 SHALL verify: reset, then start=1 for one cycle with n_iter=1 -> LOADX, STEP1..STEP4 control words per REQ-014..018 on consecutive cycles, done=1 exactly 5 edges after start accepted, iter_cnt=1, then IDLE.
REQ-034 SHALL verify: n_iter=3 -> STEP1..STEP4 sequence repeats 3 times, done 13 edges after start accepted, iter_cnt=3.
REQ-035 SHALL verify: n_iter=0 -> behaves as n_iter=1 (done at 5 edges, iter_cnt=1).
REQ-036 SHALL verify: abort=1 in STEP3 of iteration 2 (n_iter=4) -> IDLE next edge, done never asserted, iter_cnt=1, all outputs 0.
REQ-037 SHALL verify: start pulsed and n_iter changed during busy -> no effect, done timing unchanged; start with abort=1 in IDLE -> stays IDLE.
REQ-038 SHALL verify: reset asserted in STEP2 -> next cycle IDLE, busy=0, iter_cnt=0, no done pulse.

Source files
------------

// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl: Moore sequencer that runs a datapath program of
// LOADX followed by N four-step iterations (STEP1..STEP4), then DONE.
// Emits register-load strobes and mux selects decoded from the state.
// Supports a synchronous abort and counts completed iterations.
module datapath_seq_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_iter,
    output logic             LX,
    output logic             LS,
    output logic             LH,
    output logic             H,
    output logic [1:0]       M0,
    output logic [1:0]       M1,
    output logic [1:0]       M2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADX = 3'd1,
        S_STEP1 = 3'd2,
        S_STEP2 = 3'd3,
        S_STEP3 = 3'd4,
        S_STEP4 = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [CNT_W-1:0] n_lat_q, n_lat_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = iter_cnt_q + CNT_ONE;

    // Next-state, iteration counter and latched-count update.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = S_IDLE;
        iter_cnt_d = iter_cnt_q;
        n_lat_d    = n_lat_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d    = S_LOADX;
                    iter_cnt_d = '0;
                    // A requested count of zero runs a single iteration.
                    n_lat_d    = (n_iter == '0) ? CNT_ONE : n_iter;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOADX: state_d = S_STEP1;
            S_STEP1: state_d = S_STEP2;
            S_STEP2: state_d = S_STEP3;
            S_STEP3: state_d = S_STEP4;
            S_STEP4: begin
                iter_cnt_d = cnt_inc;
                state_d    = (cnt_inc < n_lat_q) ? S_STEP1 : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort cancels any running program; the count keeps its value.
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            iter_cnt_d = iter_cnt_q;
            n_lat_d    = n_lat_q;
        end
    end

    // State, counter and latched-count registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs, independent of block order.
        if (reset) begin
            state_q    <= S_IDLE;
            iter_cnt_q <= '0;
            n_lat_q    <= CNT_ONE;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            n_lat_q    <= n_lat_d;
        end
    end

    // Moore output decode: control word, busy and done from state only.
    always_comb begin
        LX   = 1'b0;
        LS   = 1'b0;
        LH   = 1'b0;
        H    = 1'b0;
        M0   = 2'd0;
        M1   = 2'd0;
        M2   = 2'd0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_LOADX: begin
                busy = 1'b1;
                LX   = 1'b1;
                M1   = 2'd1;
                LH   = 1'b1;
                H    = 1'b1;
            end
            S_STEP1: begin
                busy = 1'b1;
                M0   = 2'd1;
                M2   = 2'd3;
                LS   = 1'b1;
                H    = 1'b1;
            end
            S_STEP2: begin
                busy = 1'b1;
                M0   = 2'd2;
                LH   = 1'b1;
                H    = 1'b1;
            end
            S_STEP3: begin
                busy = 1'b1;
                M1   = 2'd2;
                M2   = 2'd3;
                LS   = 1'b1;
            end
            S_STEP4: begin
                busy = 1'b1;
                M0   = 2'd3;
                M2   = 2'd2;
                LS   = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            // Unused encodings present an all-zero word while they recover.
            default: ;
        endcase
    end

    assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Scoreboard bench for datapath_seq_ctrl: the stimulus process pushes the
// hand-derived expected control word and count for every clock edge it
// drives; the monitor pops and compares on the following falling edge.
module tb_datapath_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] n_iter;
    logic       LX, LS, LH, H;
    logic [1:0] M0, M1, M2;
    logic       busy, done;
    logic [3:0] iter_cnt;

    datapath_seq_ctrl #(.CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .n_iter   (n_iter),
        .LX       (LX),
        .LS       (LS),
        .LH       (LH),
        .H        (H),
        .M0       (M0),
        .M1       (M1),
        .M2       (M2),
        .busy     (busy),
        .done     (done),
        .iter_cnt (iter_cnt)
    );

    // Expected word layout: {LX,LS,LH,H, M0, M1, M2, busy, done}
    localparam logic [11:0] W_IDLE  = {4'b0000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    localparam logic [11:0] W_LOADX = {4'b1011, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0};
    localparam logic [11:0] W_STEP1 = {4'b0101, 2'd1, 2'd0, 2'd3, 1'b1, 1'b0};
    localparam logic [11:0] W_STEP2 = {4'b0011, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0};
    localparam logic [11:0] W_STEP3 = {4'b0100, 2'd0, 2'd2, 2'd3, 1'b1, 1'b0};
    localparam logic [11:0] W_STEP4 = {4'b0100, 2'd3, 2'd0, 2'd2, 1'b1, 1'b0};
    localparam logic [11:0] W_DONE  = {4'b0000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1};

    typedef struct {
        logic [11:0] word;
        logic [3:0]  cnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs and record what the DUT must show after the edge.
    task automatic step(input logic st, input logic ab, input logic rst,
                        input logic [3:0] n, input logic [11:0] w,
                        input logic [3:0] c, input string tag);
        exp_t e;
        start  = st;
        abort  = ab;
        reset  = rst;
        n_iter = n;
        e.word = w;
        e.cnt  = c;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Idle cycle with quiet inputs.
    task automatic idle(input logic [3:0] c, input string tag);
        step(1'b0, 1'b0, 1'b0, 4'd0, W_IDLE, c, tag);
    endtask

    // Accept a start and walk a full program of nit iterations through DONE.
    // While busy, start is held high and n_iter scrambled when noisy is set.
    task automatic run_prog(input logic [3:0] n_req, input int nit,
                            input logic noisy, input string tag);
        logic       ns;
        logic [3:0] nn;
        ns = noisy;
        nn = noisy ? 4'd7 : 4'd0;
        step(1'b1, 1'b0, 1'b0, n_req, W_LOADX, 4'd0, {tag, "_loadx"});
        for (int i = 0; i < nit; i++) begin
            step(ns, 1'b0, 1'b0, nn, W_STEP1, 4'(i), {tag, "_step1"});
            step(ns, 1'b0, 1'b0, nn, W_STEP2, 4'(i), {tag, "_step2"});
            step(ns, 1'b0, 1'b0, nn, W_STEP3, 4'(i), {tag, "_step3"});
            step(ns, 1'b0, 1'b0, nn, W_STEP4, 4'(i), {tag, "_step4"});
        end
        // Inputs applied in STEP4's cycle; the edge lands in DONE.
        step(1'b0, 1'b0, 1'b0, 4'd0, W_DONE, 4'(nit), {tag, "_done"});
        idle(4'(nit), {tag, "_idle"});
    endtask

    // Monitor: compare each observed cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, "_ctrl"}, {LX, LS, LH, H, M0, M1, M2, busy, done}, e.word);
                check({e.tag, "_cnt"}, {8'd0, iter_cnt}, {8'd0, e.cnt});
            end
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        start  = 1'b0;
        abort  = 1'b0;
        reset  = 1'b1;
        n_iter = 4'd0;

        // Reset with start and abort active must still land in IDLE.
        step(1'b1, 1'b1, 1'b1, 4'd5, W_IDLE, 4'd0, "reset0");
        step(1'b1, 1'b0, 1'b1, 4'd5, W_IDLE, 4'd0, "reset1");
        idle(4'd0, "post_reset");

        // Single iteration: DONE on the 5th edge after acceptance.
        run_prog(4'd1, 1, 1'b0, "n1");
        idle(4'd1, "n1_hold");

        // Three iterations: DONE on the 13th edge.
        run_prog(4'd3, 3, 1'b0, "n3");

        // Zero count behaves as one.
        run_prog(4'd0, 1, 1'b0, "n0");

        // Abort in STEP3 of iteration 2 with n_iter=4.
        step(1'b1, 1'b0, 1'b0, 4'd4, W_LOADX, 4'd0, "ab_loadx");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP1, 4'd0, "ab_i1s1");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP2, 4'd0, "ab_i1s2");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP3, 4'd0, "ab_i1s3");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP4, 4'd0, "ab_i1s4");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP1, 4'd1, "ab_i2s1");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP2, 4'd1, "ab_i2s2");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP3, 4'd1, "ab_i2s3");
        step(1'b0, 1'b1, 1'b0, 4'd0, W_IDLE,  4'd1, "ab_idle");
        idle(4'd1, "ab_hold1");
        idle(4'd1, "ab_hold2");

        // start and n_iter changes while busy are ignored (n_iter=2 program).
        run_prog(4'd2, 2, 1'b1, "busy_noise");

        // start together with abort in IDLE is refused.
        step(1'b1, 1'b1, 1'b0, 4'd3, W_IDLE, 4'd2, "start_abort0");
        step(1'b1, 1'b1, 1'b0, 4'd3, W_IDLE, 4'd2, "start_abort1");
        idle(4'd2, "start_abort_hold");

        // Reset in STEP2 of iteration 2 terminates the program with no done.
        step(1'b1, 1'b0, 1'b0, 4'd3, W_LOADX, 4'd2 - 4'd2, "rst_loadx");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP1, 4'd0, "rst_i1s1");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP2, 4'd0, "rst_i1s2");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP3, 4'd0, "rst_i1s3");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP4, 4'd0, "rst_i1s4");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP1, 4'd1, "rst_i2s1");
        step(1'b0, 1'b0, 1'b0, 4'd0, W_STEP2, 4'd1, "rst_i2s2");
        step(1'b0, 1'b0, 1'b1, 4'd0, W_IDLE,  4'd0, "rst_idle");
        idle(4'd0, "rst_hold1");
        idle(4'd0, "rst_hold2");

        // Let the monitor drain, bounded by a few cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
